// File: rtl/muestreador_os_pkg.sv
// Shared sizing for the oversampling front end: default parameters and counter widths.
// Designs derive their own widths from their parameters with the helper below.
package muestreador_os_pkg;

    localparam int SAMPLES_DEF = 2;
    localparam int OSF_DEF     = 8;
    localparam int CLK_DIV_DEF = 16;

    // Counter width for a modulus-n counter, never narrower than one bit
    function automatic int ancho(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int W      = SAMPLES_DEF * OSF_DEF;
    localparam int DIV_W  = ancho(CLK_DIV_DEF);
    localparam int FILL_W = $clog2(W + 1);
    localparam int PH_W   = ancho(OSF_DEF);

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for one asynchronous bit; 2 clk latency, reset to RST_VAL.
// No flow control: follows the input every cycle.
module sincronizador_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/muestreador_os.sv
// Oversampling front end: synchronises rx, samples it every CLK_DIV clk into a SAMPLES*OSF window.
// Window strobed to the filter once per symbol via p; no back-pressure, consumer keeps up by design.
module muestreador_os
    import muestreador_os_pkg::*;
#(
    parameter int SAMPLES = SAMPLES_DEF,
    parameter int OSF     = OSF_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     rx,
    output logic [SAMPLES*OSF-1:0]   data_out,
    output logic                     p,
    output logic                     filled
);

    localparam int WV      = SAMPLES * OSF;
    localparam int DIV_WV  = ancho(CLK_DIV);
    localparam int FILL_WV = $clog2(WV + 1);
    localparam int PH_WV   = ancho(OSF);

    logic               rx_sync;
    logic [DIV_WV-1:0]  div_cnt;
    logic [FILL_WV-1:0] fill_cnt;
    logic [PH_WV-1:0]   phase_cnt;
    logic [WV-1:0]      shreg;
    logic [WV-1:0]      shreg_nxt;
    logic               tick;
    logic               strobe;

    sincronizador_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_sync)
    );

    assign tick      = en && (div_cnt == DIV_WV'(CLK_DIV - 1));
    assign shreg_nxt = {shreg[WV-2:0], rx_sync};

    // First strobe when the window just filled, then once per symbol while full
    assign strobe = (fill_cnt == FILL_WV'(WV - 1)) ||
                    ((fill_cnt == FILL_WV'(WV)) && (phase_cnt == PH_WV'(OSF - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            fill_cnt  <= '0;
            phase_cnt <= '0;
            shreg     <= '0;
            data_out  <= '0;
            p         <= 1'b0;
            filled    <= 1'b0;
        end else if (!en) begin
            // Window contents survive a pause; the fill restarts from zero
            div_cnt   <= '0;
            fill_cnt  <= '0;
            phase_cnt <= '0;
            p         <= 1'b0;
            filled    <= 1'b0;
        end else begin
            p <= 1'b0;
            if (tick) begin
                div_cnt <= '0;
                shreg   <= shreg_nxt;
                if (fill_cnt != FILL_WV'(WV)) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
                if (fill_cnt == FILL_WV'(WV - 1)) begin
                    filled <= 1'b1;
                end
                phase_cnt <= (phase_cnt == PH_WV'(OSF - 1)) ? '0 : phase_cnt + 1'b1;
                if (strobe) begin
                    data_out <= shreg_nxt;
                    p        <= 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muestreador_os.sv
// Bench for muestreador_os: directed scenarios plus random traffic against a tick/strobe schedule model.
module tb_muestreador_os;

    localparam int SAMPLES = 2;
    localparam int OSF     = 8;
    localparam int W       = SAMPLES * OSF;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         en1;
    logic         rx;
    logic [W-1:0] data_out;
    logic [W-1:0] data_out1;
    logic         p;
    logic         p1;
    logic         filled;
    logic         filled1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muestreador_os #(.SAMPLES(SAMPLES), .OSF(OSF), .CLK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rx       (rx),
        .data_out (data_out),
        .p        (p),
        .filled   (filled)
    );

    muestreador_os #(.SAMPLES(SAMPLES), .OSF(OSF), .CLK_DIV(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .en       (en1),
        .rx       (rx),
        .data_out (data_out1),
        .p        (p1),
        .filled   (filled1)
    );

    // Reference: rx seen two edges late; tick every div-th enabled cycle;
    // strobe on tick number W, W+OSF, W+2*OSF, ... counted since the last restart.
    logic         m_d1 [2];
    logic         m_d2 [2];
    int           m_en_cnt [2];
    int           m_ticks [2];
    logic [W-1:0] m_win [2];
    logic [W-1:0] m_data [2];
    logic         m_p [2];
    logic         m_filled [2];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input int div, input logic r, input logic e, input logic x);
        logic s;
        s = m_d2[i];
        if (r) begin
            m_d1[i] = 1'b1;     m_d2[i] = 1'b1;
            m_en_cnt[i] = 0;    m_ticks[i] = 0;
            m_win[i] = '0;      m_data[i] = '0;
            m_p[i] = 1'b0;      m_filled[i] = 1'b0;
        end else begin
            m_d2[i] = m_d1[i];
            m_d1[i] = x;
            m_p[i]  = 1'b0;
            if (!e) begin
                m_en_cnt[i] = 0;
                m_ticks[i]  = 0;
                m_filled[i] = 1'b0;
            end else begin
                m_en_cnt[i]++;
                if (m_en_cnt[i] % div == 0) begin
                    m_ticks[i]++;
                    m_win[i] = {m_win[i][W-2:0], s};
                    if (m_ticks[i] >= W) begin
                        m_filled[i] = 1'b1;
                        if ((m_ticks[i] - W) % OSF == 0) begin
                            m_p[i]    = 1'b1;
                            m_data[i] = m_win[i];
                        end
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic e1, input logic x);
        rst = r; en = e; en1 = e1; rx = x;
        @(posedge clk);
        model_step(0, 4, r, e, x);
        model_step(1, 1, r, e1, x);
        #1;
        check("data_out", data_out, m_data[0]);
        check("p", W'(p), W'(m_p[0]));
        check("filled", W'(filled), W'(m_filled[0]));
        check("data_out_div1", data_out1, m_data[1]);
        check("p_div1", W'(p1), W'(m_p[1]));
        check("filled_div1", W'(filled1), W'(m_filled[1]));
    endtask

    typedef struct {
        logic         a;
        logic         b;
        logic         c;
        logic [W-1:0] exp1;
        logic [W-1:0] exp2;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int           np;
        int           first;
        int           second;
        int           blk;
        logic         x;
        logic         xr;
        logic         er;
        logic         er1;
        logic [W-1:0] saved;

        vecs[0] = '{a: 1'b1, b: 1'b0, c: 1'b1, exp1: 16'hFF00, exp2: 16'h00FF};
        vecs[1] = '{a: 1'b0, b: 1'b1, c: 1'b0, exp1: 16'h00FF, exp2: 16'hFF00};
        vecs[2] = '{a: 1'b1, b: 1'b1, c: 1'b0, exp1: 16'hFFFF, exp2: 16'hFF00};
        vecs[3] = '{a: 1'b0, b: 1'b0, c: 1'b1, exp1: 16'h0000, exp2: 16'h00FF};

        // Reset with rx toggling, then a long idle stretch with en low
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, i[0]);
        check("reset_data", data_out, 16'h0000);
        np = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b0, 1'b0, i[1]);
            if (p) np++;
        end
        check("no_p_while_disabled", W'(np), W'(0));

        // Constant mark: first strobe at the 16th tick, then every 32 clk
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        np = 0; first = 0; second = 0;
        for (int e = 1; e <= 130; e++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1);
            if (p) begin
                np++;
                if (np == 1) first = e;
                if (np == 2) second = e;
                check("mark_data", data_out, 16'hFFFF);
                check("mark_filled", W'(filled), W'(1));
            end
        end
        check("first_p_edge", W'(first), W'(64));
        check("p_period", W'(second - first), W'(32));
        check("p_count", W'(np), W'(3));

        // Block patterns, rx changes 3 clk ahead of each tick
        for (int v = 0; v < 4; v++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1);
            cyc(1'b1, 1'b0, 1'b0, 1'b1);
            np = 0;
            for (int e = 1; e <= 100; e++) begin
                blk = (((e + 3) / 4) - 1) / 8;
                x = (blk == 0) ? vecs[v].a : (blk == 1) ? vecs[v].b : vecs[v].c;
                cyc(1'b0, 1'b1, 1'b0, x);
                if (p) begin
                    np++;
                    if (np == 1) check("pattern_first", data_out, vecs[v].exp1);
                    if (np == 2) check("pattern_second", data_out, vecs[v].exp2);
                end
            end
            check("pattern_p_count", W'(np), W'(2));
        end

        // Pause after 10 ticks: window holds, fill restarts
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int e = 1; e <= 64; e++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("pre_pause_data", data_out, 16'hFFFF);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int e = 1; e <= 40; e++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        saved = data_out;
        for (int e = 1; e <= 5; e++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("pause_filled", W'(filled), W'(0));
        check("pause_hold", data_out, saved);
        first = 0;
        for (int e = 1; e <= 70; e++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            if (p && first == 0) begin
                first = e;
                check("resume_data", data_out, 16'h0000);
            end
            if (first == 0) check("resume_hold", data_out, 16'hFFFF);
        end
        check("resume_first_p", W'(first), W'(64));

        // Reset landing on the strobe tick wins
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int e = 1; e <= 63; e++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("rst_on_strobe_p", W'(p), W'(0));
        check("rst_on_strobe_data", data_out, 16'h0000);
        first = 0;
        for (int e = 1; e <= 70; e++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1);
            if (p && first == 0) first = e;
        end
        check("after_rst_first_p", W'(first), W'(64));

        // CLK_DIV=1 instance: tick every enabled cycle
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        np = 0; first = 0; second = 0;
        for (int e = 1; e <= 40; e++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
            if (p1) begin
                np++;
                if (np == 1) first = e;
                if (np == 2) second = e;
                check("div1_data", data_out1, 16'hFFFF);
            end
        end
        check("div1_first_p", W'(first), W'(16));
        check("div1_period", W'(second - first), W'(8));

        // Random traffic: bursty rx, occasional pauses and resets
        xr = 1'b1; er = 1'b1; er1 = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) xr = ~xr;
            if ($urandom_range(0, 99) == 0) er = ~er;
            else if (!er && $urandom_range(0, 3) == 0) er = 1'b1;
            if ($urandom_range(0, 99) == 0) er1 = ~er1;
            else if (!er1 && $urandom_range(0, 3) == 0) er1 = 1'b1;
            cyc($urandom_range(0, 499) == 0, er, er1, xr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muestreador_os.md
Name: muestreador_os

Overview:
Oversampling front end that sits directly upstream of the low-pass/majority filter stage (SAMPLES, OSF, DataIn, P). It synchronises the asynchronous serial line and samples it OSF times per symbol using a clock-divider tick. The samples are shifted into a sliding window of SAMPLES*OSF bits. A one-cycle strobe presents a stable window to the filter once per symbol period.

Parameters:
SAMPLES, 2, symbols held in the window (>=1)
OSF, 8, oversampling factor, samples per symbol (>=2)
CLK_DIV, 16, clk cycles per oversample tick (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  sampling enable
rx  in  1  asynchronous serial line, idle high
data_out  out  SAMPLES*OSF  sample window to filter DataIn; newest sample at bit 0
p  out  1  one-cycle strobe: data_out updated this cycle (filter P)
filled  out  1  window holds SAMPLES*OSF valid samples since last en/rst

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- W = SAMPLES*OSF.
- Reset values: data_out=0, p=0, filled=0, shift register=0, all counters=0, synchroniser stages=1.
- rx passes through a 2-FF synchroniser, 2 clk latency, reset value 1. The synchroniser runs regardless of en.
- Divider: div_cnt counts 0..CLK_DIV-1 while en=1. tick=1 in the cycle div_cnt==CLK_DIV-1 and en=1, then div_cnt wraps to 0. With CLK_DIV=1, tick=en every cycle.
- On tick: shreg <= {shreg[W-2:0], rx_sync}. fill_cnt (width $clog2(W+1)) increments and saturates at W. phase_cnt (width $clog2(OSF)) increments and wraps OSF-1 -> 0.
- filled is registered; it rises at the edge where fill_cnt reaches W.
- Strobe condition on a tick: the window becomes full on this tick (fill_cnt goes W-1 -> W), or the window is already full and phase_cnt wraps to 0.
  - Result: first p at the W-th tick, then every OSF ticks.
- On a strobe tick, at the same edge: data_out <= {shreg[W-2:0], rx_sync} and p <= 1. p is high for exactly one clk; data_out holds until the next strobe.
- Latency: an rx edge is visible in shreg at the first tick at least 2 clk after it.
- en=0:
  - div_cnt, phase_cnt and fill_cnt clear to 0; filled clears; p=0.
  - shreg and data_out hold.
  - Re-enable restarts filling from zero: the next p comes W ticks later.
- rst=1 takes priority over en and tick. A tick coinciding with rst is discarded; all outputs reach reset values the next cycle.
- No strobe back-pressure: the filter consumes data_out within one symbol period (OSF*CLK_DIV clk).

Decomposition:
- Shared package: localparam W, DIV_W=$clog2(CLK_DIV) (min 1), FILL_W=$clog2(W+1), PH_W=$clog2(OSF) (min 1).
- One sub-module: sincronizador_2ff (1-bit, 2 stages, synchronous reset to a parameterised reset value of 1).

Test Plan:
(bench: SAMPLES=2, OSF=8, CLK_DIV=4, W=16)
1. rst high 5 cycles with en=0, rx toggling -> data_out=16'h0000, p=0, filled=0 throughout; p never asserts for 100 cycles with en=0.
2. rx=1 constant, en=1 after reset -> first p at 16th tick (clk 64 after en), data_out=16'hFFFF, filled=1. Subsequent p every 32 clk, each exactly 1 cycle wide.
3. rx=1 for 8 ticks then 0 for 8 ticks, transitions driven 3 clk before tick boundaries -> first p data_out=16'hFF00; after 8 more ticks of rx=1, p with data_out=16'h00FF.
4. en=0 for 5 cycles after 10 ticks, then en=1 -> no p until 16 further ticks, filled=0 meanwhile, data_out unchanged from before.
5. rst asserted in the same cycle as a strobe tick -> p=0 and data_out=0 the next cycle; next p only 16 ticks after rst release with en=1.
6. Re-parameterise CLK_DIV=1, rx=1, en=1 -> first p 16 clk after en, then every 8 clk; data_out=16'hFFFF.
